mux2_sel_seq: RTL
=================

Name: mux2_sel_seq

Overview:
- Upstream driver stage for the 4-bit 2:1 selector.
- Holds the two operand registers `a` and `b`, loaded from a shared data bus.
- Generates the select line `s` under a small FSM: force-A, force-B, continuous alternate with a programmable dwell, or a fixed-length burst.
- All outputs are registered. The selector downstream stays purely combinational.

Parameters:
- WIDTH, 4, operand width (must match the selector data width)
- CNT_W, 4, width of the dwell counter and of the `period` input
- BURST_TGL, 8, number of `s` toggles in burst mode (even, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- din  in  WIDTH  operand load data
- ld_a  in  1  load `din` into `a` at the next edge
- ld_b  in  1  load `din` into `b` at the next edge
- mode  in  2  00 force A, 01 force B, 10 alternate, 11 burst; sampled on `start`
- period  in  CNT_W  dwell minus one (cycles per `s` phase = period+1); sampled on `start`
- start  in  1  begin the sequence in `mode`; ignored while busy
- stop  in  1  synchronous abort to IDLE
- a  out  WIDTH  operand A to selector
- b  out  WIDTH  operand B to selector
- s  out  1  select to selector (0 = a, 1 = b)
- busy  out  1  high while not IDLE
- tgl  out  1  one-cycle pulse, coincident with every change of `s` in ALT/BURST

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: a=0, b=0, s=0, busy=0, tgl=0.
  - Internal: state=IDLE, cnt=0, tcnt=0, mode_q=0, period_q=0.
- Operand loads:
  - Independent of FSM state.
  - `ld_a` → a<=din; `ld_b` → b<=din.
  - Both high in the same cycle → both load `din`.
  - A load never affects `s`, `cnt` or the state.
- States: IDLE, FORCE_A, FORCE_B, ALT, BURST.
- IDLE:
  - s=0, busy=0.
  - `start` && !`stop` → capture mode_q/period_q, clear cnt/tcnt, go to the state selected by `mode`.
  - s=1 if mode=01, else 0.
  - busy=1 from the same edge; 1-cycle latency start→outputs.
- FORCE_A / FORCE_B:
  - `s` is held at 0 / 1 until `stop`.
- ALT, each cycle:
  - cnt==period_q → cnt<=0, s<=~s, tgl<=1.
  - Otherwise cnt<=cnt+1, tgl<=0.
  - period_q=0 → `s` toggles every cycle.
  - First toggle occurs period_q+1 cycles after entry.
- BURST:
  - Same timing as ALT; tcnt increments on each toggle.
  - On toggle number BURST_TGL, at that same edge: s<=0 (naturally 0, since BURST_TGL is even), tgl pulses, state<=IDLE, busy<=0.
- `stop` (any non-IDLE state):
  - Next edge → IDLE, s=0, busy=0, tgl=0, cnt=0, tcnt=0.
  - `stop` has priority over both `start` and a coincident toggle; no tgl pulse is emitted.
- `start` while busy is ignored.
- `mode`/`period` changes while busy have no effect until the next accepted start.
- Counter widths:
  - cnt is CNT_W bits and never exceeds period_q, so there is no wrap.
  - tcnt is $clog2(BURST_TGL)+1 bits.
- `reset` asserted mid-sequence → immediate return to the reset values, including a and b.
- `tgl` is low in every state except ALT/BURST toggle cycles.

Decomposition:
- Package mux2_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, FORCE_A, FORCE_B, ALT, BURST};
  - typedef enum logic [1:0] mode_t {M_A, M_B, M_ALT, M_BURST};
  - localparam default WIDTH=4.
- One natural sub-module: mux2_dwell_cnt. It holds cnt, compares against period_q, and produces a `wrap` strobe used for the toggle.
- Operand registers and the FSM stay in the top module.
- A top-level bench instantiates mux2_sel_seq feeding the existing selector and checks y.

Test Plan:
- Reset then idle: assert reset mid-cycle → a=0, b=0, s=0, busy=0 immediately (no clock edge); downstream y=0.
- Loads: din=4'hA with ld_a, then din=4'h5 with ld_b, then din=4'h3 with both → a=3, b=3. Before the simultaneous load, force B gives y=5 and force A gives y=A.
- Alternate: a=1, b=2, mode=10, period=2, start → s=0 for 3 cycles, then 1 for 3 cycles, repeating. tgl pulses every 3rd cycle. Downstream y follows 1,1,1,2,2,2,…
- Burst period 0: mode=11, period=0, start → s toggles every cycle, 8 tgl pulses. busy falls at the edge of the 8th toggle with s=0. A start issued during the burst is ignored.
- Stop priority: in ALT with period=1, assert stop in the cycle where cnt==period → next edge IDLE, s=0, no tgl. Start+stop together in IDLE → stays IDLE.
- Reset mid-burst: after 3 toggles assert reset → all outputs 0. Release, then start mode=01 → s=1, busy=1 after one edge.

Source files
------------

// File: rtl/mux2_pkg.sv
// Shared types and defaults for the mux2 selector driver slice.
package mux2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FORCE_A = 3'd1,
    FORCE_B = 3'd2,
    ALT     = 3'd3,
    BURST   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    M_A     = 2'b00,
    M_B     = 2'b01,
    M_ALT   = 2'b10,
    M_BURST = 2'b11
  } mode_t;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_CNT_W     = 4;
  localparam int unsigned DEF_BURST_TGL = 8;

  // State entered from IDLE on an accepted start.
  function automatic state_t state_for_mode(input mode_t m);
    state_t st;
    st = IDLE;
    case (m)
      M_A:     st = FORCE_A;
      M_B:     st = FORCE_B;
      M_ALT:   st = ALT;
      M_BURST: st = BURST;
      default: st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mux2_dwell_cnt.sv
// Dwell counter: counts 0..period and strobes wrap on the terminal count.
module mux2_dwell_cnt
  import mux2_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  assign wrap = en && (cnt == period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux2_sel_seq.sv
// Operand registers and select-line sequencer driving the 4-bit 2:1 selector.
module mux2_sel_seq
  import mux2_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned BURST_TGL = DEF_BURST_TGL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             s,
  output logic             busy,
  output logic             tgl
);

  localparam int unsigned TC_W = $clog2(BURST_TGL) + 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(BURST_TGL - 1);

  state_t           state;
  mode_t            mode_q;
  logic [CNT_W-1:0] period_q;
  logic [TC_W-1:0]  tcnt;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             cnt_clr;
  logic             cnt_en;
  logic             accept;
  logic             toggling;

  assign accept   = (state == IDLE) && start && !stop;
  assign toggling = (state == ALT) || (state == BURST);

  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (accept || (state != IDLE && stop)) begin
      cnt_clr = 1'b1;
    end else if (toggling) begin
      cnt_en = 1'b1;
    end
  end

  mux2_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .period (period_q),
    .cnt    (cnt),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
    end else begin
      if (ld_a) a <= din;
      if (ld_b) b <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= M_A;
      period_q <= '0;
      tcnt     <= '0;
      s        <= 1'b0;
      busy     <= 1'b0;
      tgl      <= 1'b0;
    end else begin
      tgl <= 1'b0;
      case (state)
        IDLE: begin
          s    <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            mode_q   <= mode_t'(mode);
            period_q <= period;
            tcnt     <= '0;
            state    <= state_for_mode(mode_t'(mode));
            s        <= (mode_t'(mode) == M_B);
            busy     <= 1'b1;
          end
        end
        FORCE_A, FORCE_B: begin
          if (stop) begin
            state <= IDLE;
            s     <= 1'b0;
            busy  <= 1'b0;
            tcnt  <= '0;
          end
        end
        ALT, BURST: begin
          if (stop) begin
            state <= IDLE;
            s     <= 1'b0;
            busy  <= 1'b0;
            tcnt  <= '0;
          end else if (wrap) begin
            s   <= ~s;
            tgl <= 1'b1;
            if (mode_q == M_BURST) begin
              // Final burst toggle lands s on 0 because BURST_TGL is even.
              if (tcnt == TC_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
                tcnt  <= '0;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          s     <= 1'b0;
          busy  <= 1'b0;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule
